// File: rtl/lsu_mem.sv
// lsu_mem: M-stage load/store unit front end.
// Turns a pipeline load/store request into a single-beat doubleword memory
// request and extends the returned load data.
//
// Ports:
//   clk, rst_n            rising-edge clock, async active-low reset
//   memreadM, memwriteM   M-stage load / store request
//   RW_typeM              access type (B,H,W,D,BU,HU,WU; 111 illegal)
//   addrM, wdataM         byte address and right-justified store data
//   dmem_req/we/addr/be/wdata   request to data memory
//   dmem_gnt              request accepted this cycle
//   dmem_rvalid/rdata     load data return
//   stallM                freeze IF..M pipeline registers
//   ldataM, lvalidM       extended load result and its valid strobe
//   misalignM             misaligned or illegal access (one cycle)
module lsu_mem (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        memreadM,
    input  logic        memwriteM,
    input  logic [2:0]  RW_typeM,
    input  logic [63:0] addrM,
    input  logic [63:0] wdataM,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [63:0] dmem_addr,
    output logic [7:0]  dmem_be,
    output logic [63:0] dmem_wdata,
    input  logic        dmem_gnt,
    input  logic        dmem_rvalid,
    input  logic [63:0] dmem_rdata,
    output logic        stallM,
    output logic [63:0] ldataM,
    output logic        lvalidM,
    output logic        misalignM
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT
    } state_t;

    state_t      state;
    state_t      state_next;

    logic [2:0]  type_q;
    logic [2:0]  off_q;

    logic        is_rd;
    logic        is_wr;
    logic        type_ok;
    logic        aligned;
    logic        access_ok;
    logic [7:0]  base_mask;
    logic        req;
    logic        stall;
    logic        lvalid;
    logic        misalign;
    logic        load_grant;
    logic [63:0] shifted;
    logic [63:0] load_ext;

    // Access decode. Types 100..110 share the size encoding in bits [1:0]
    // with their signed counterparts.
    always_comb begin
        is_rd   = memreadM & ~memwriteM;
        is_wr   = memwriteM & ~memreadM;
        type_ok = (RW_typeM != 3'b111) && !(is_wr && RW_typeM[2]);
        case (RW_typeM[1:0])
            2'b00: begin aligned = 1'b1;                base_mask = 8'h01; end
            2'b01: begin aligned = ~addrM[0];           base_mask = 8'h03; end
            2'b10: begin aligned = (addrM[1:0] == 2'b00);  base_mask = 8'h0F; end
            default: begin aligned = (addrM[2:0] == 3'b000); base_mask = 8'hFF; end
        endcase
        access_ok = (is_rd | is_wr) & type_ok & aligned;
    end

    // Next state and control. Inputs are held stable while stalled, so in
    // REQ the live request decode still identifies load vs store.
    always_comb begin
        state_next = state;
        req        = 1'b0;
        stall      = 1'b0;
        lvalid     = 1'b0;
        misalign   = 1'b0;
        load_grant = 1'b0;
        case (state)
            IDLE: begin
                if (access_ok) begin
                    req = 1'b1;
                    if (is_wr) begin
                        if (!dmem_gnt) begin
                            stall      = 1'b1;
                            state_next = REQ;
                        end
                    end else begin
                        stall = 1'b1;
                        if (dmem_gnt) begin
                            load_grant = 1'b1;
                            state_next = WAIT;
                        end else begin
                            state_next = REQ;
                        end
                    end
                end else if (memreadM || memwriteM) begin
                    misalign = 1'b1;
                end
            end
            REQ: begin
                req   = 1'b1;
                stall = 1'b1;
                if (dmem_gnt) begin
                    if (is_wr) begin
                        stall      = 1'b0;
                        state_next = IDLE;
                    end else begin
                        load_grant = 1'b1;
                        state_next = WAIT;
                    end
                end
            end
            WAIT: begin
                stall = 1'b1;
                if (dmem_rvalid) begin
                    stall      = 1'b0;
                    lvalid     = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        // Outputs are combinational from the inputs, so reset must mask
        // them explicitly rather than relying on the IDLE state alone.
        if (!rst_n) begin
            state_next = IDLE;
            req        = 1'b0;
            stall      = 1'b0;
            lvalid     = 1'b0;
            misalign   = 1'b0;
            load_grant = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            type_q <= '0;
            off_q  <= '0;
        end else begin
            state <= state_next;
            if (load_grant) begin
                type_q <= RW_typeM;
                off_q  <= addrM[2:0];
            end
        end
    end

    // Load alignment and extension use the copies captured at grant.
    always_comb begin
        shifted = dmem_rdata >> {off_q, 3'b000};
        case (type_q)
            3'b000:  load_ext = {{56{shifted[7]}},  shifted[7:0]};
            3'b001:  load_ext = {{48{shifted[15]}}, shifted[15:0]};
            3'b010:  load_ext = {{32{shifted[31]}}, shifted[31:0]};
            3'b100:  load_ext = {56'd0, shifted[7:0]};
            3'b101:  load_ext = {48'd0, shifted[15:0]};
            3'b110:  load_ext = {32'd0, shifted[31:0]};
            default: load_ext = shifted;
        endcase
    end

    always_comb begin
        dmem_req   = req;
        dmem_we    = req & is_wr;
        dmem_addr  = {addrM[63:3], 3'b000};
        dmem_be    = req ? (base_mask << addrM[2:0]) : '0;
        dmem_wdata = wdataM << {addrM[2:0], 3'b000};
        stallM     = stall;
        lvalidM    = lvalid;
        misalignM  = misalign;
        ldataM     = lvalid ? load_ext : '0;
    end

endmodule

// File: doc/lsu_mem.md
LSU_MEM -- requirements
Module: lsu_mem

Interface
REQ-001 SHALL have the following ports:
- clk  in  1  pipeline clock, rising-edge.
- rst_n  in  1  reset, asynchronous, active-low.
- memreadM  in  1  M-stage load request.
- memwriteM  in  1  M-stage store request.
- RW_typeM  in  3  access type: 000 B, 001 H, 010 W, 011 D, 100 BU, 101 HU, 110 WU; 111 is illegal.
- addrM  in  64  effective byte address.
- wdataM  in  64  store data, right-justified.
- dmem_req  out  1  memory request.
- dmem_we  out  1  1 = store.
- dmem_addr  out  64  doubleword address: addrM with bits [2:0] = 0.
- dmem_be  out  8  byte enables.
- dmem_wdata  out  64  store data shifted to its byte lane.
- dmem_gnt  in  1  request accepted this cycle.
- dmem_rvalid  in  1  load data valid this cycle.
- dmem_rdata  in  64  load doubleword.
- stallM  out  1  freeze IF..M pipeline registers.
- ldataM  out  64  extended load result.
- lvalidM  out  1  ldataM valid this cycle.
- misalignM  out  1  misaligned or illegal access, one cycle.

Function
REQ-002 SHALL use the FSM states IDLE, REQ and WAIT. REQ means the request is not yet granted; WAIT means the load is granted and data is outstanding.
REQ-003 SHALL define an access as valid when exactly one of memreadM or memwriteM is 1, RW_typeM is not 111, and the address is aligned.
- B/BU: any address.
- H/HU: addrM[0] = 0.
- W/WU: addrM[1:0] = 0.
- D: addrM[2:0] = 0.
- Store types 100..110 count as illegal.
REQ-004 SHALL, for an access that is not valid (misaligned, illegal type, or memreadM and memwriteM both 1):
- assert misalignM in that IDLE cycle;
- keep dmem_req at 0;
- keep stallM at 0.
REQ-005 SHALL, in IDLE with a valid access, drive dmem_req = 1 combinationally in that cycle.
REQ-006 SHALL, for a store in IDLE:
- if dmem_gnt = 1 in the same cycle, complete with stallM = 0 and stay in IDLE;
- otherwise assert stallM and go to REQ.
REQ-007 SHALL, for a load in IDLE:
- assert stallM;
- go to WAIT if dmem_gnt = 1, otherwise go to REQ.
REQ-008 SHALL, in REQ:
- hold dmem_req = 1 with stable address, byte enables, data and we;
- keep stallM = 1;
- on dmem_gnt, a store completes (stallM = 0 that cycle, go to IDLE) and a load goes to WAIT.
REQ-009 SHALL, in WAIT:
- keep dmem_req = 0 and stallM = 1 until dmem_rvalid;
- in the dmem_rvalid cycle, drive lvalidM = 1, ldataM valid and stallM = 0, then go to IDLE.
REQ-010 SHALL ignore dmem_rvalid outside WAIT.
REQ-011 SHALL generate dmem_be by shifting the base mask left by addrM[2:0]. Base masks: B = 0x01, H = 0x03, W = 0x0F, D = 0xFF.
REQ-012 SHALL generate dmem_wdata as wdataM shifted left by 8 × addrM[2:0].
REQ-013 SHALL form ldataM as dmem_rdata shifted right by 8 × addrM[2:0], truncated to the access size, then extended:
- sign-extended for B/H/W;
- zero-extended for BU/HU/WU;
- unchanged for D.
REQ-014 SHALL drive ldataM to 0 whenever lvalidM = 0.
REQ-015 SHALL give minimum latencies of 0 stall cycles for a store granted immediately and 1 stall cycle for a load (gnt in the issue cycle, rvalid the next cycle).
REQ-016 SHALL support back-to-back accesses: the cycle after completion may start a new access from IDLE with no bubble.
REQ-017 SHALL rely on memreadM/memwriteM/RW_typeM/addrM/wdataM being held stable while stallM = 1. It SHALL register the load's RW_typeM and addrM[2:0] at grant and use the registered copies for load extension.
REQ-018 SHALL never issue a second request while a load is outstanding.

Reset
REQ-019 SHALL, while rst_n = 0 (asynchronous), force:
- state = IDLE;
- the registered type/offset = 0;
- dmem_req = 0, stallM = 0, lvalidM = 0, misalignM = 0;
- ldataM = 0, dmem_be = 0, dmem_we = 0.
REQ-020 SHALL, on reset asserted in REQ or WAIT, abandon the access; a dmem_rvalid arriving after reset release SHALL be ignored.

Verification
REQ-021 Directed scenarios the bench SHALL cover:
- Store word: addrM = 0x1004, wdataM = 0xDEADBEEF, gnt same cycle -> dmem_addr = 0x1000, dmem_be = 0xF0, dmem_wdata = 0xDEADBEEF_00000000, stallM = 0 throughout.
- Load byte signed: addrM = 0x2003, dmem_rdata = 0x00000000_80000000, gnt at cycle 0, rvalid at cycle 2 -> stallM = 1 for cycles 0-1; at cycle 2 ldataM = 0xFFFFFFFFFFFFFF80, lvalidM = 1.
- Load halfword unsigned: addrM = 0x2006, dmem_rdata = 0xABCD0000_00000000 -> ldataM = 0x000000000000ABCD.
- Misaligned load: LW at addrM = 0x3002 -> misalignM = 1 for one cycle, dmem_req = 0, stallM = 0; likewise with memreadM = memwriteM = 1.
- Grant backpressure: SD with gnt low for 3 cycles -> dmem_req and all dmem_* fields stable for 4 cycles, stallM = 1 for 3 cycles, then a back-to-back LD issues in the following cycle.
- Reset mid-WAIT: rst_n low during WAIT, then rvalid after release -> lvalidM stays 0, state IDLE.
